// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue/writeback controller: opcodes, instruction
// field positions, FSM encoding and flag bit indices.
package alu_pkg;

  localparam logic       GRP_ARITH = 1'b0;
  localparam logic       GRP_LOGIC = 1'b1;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_ADC = 3'd1;
  localparam logic [2:0] OP_SUB = 3'd2;
  localparam logic [2:0] OP_SBB = 3'd3;
  localparam logic [2:0] OP_AND = 3'd0;
  localparam logic [2:0] OP_OR  = 3'd1;
  localparam logic [2:0] OP_ROR = 3'd2;
  localparam logic [2:0] OP_ROL = 3'd3;
  localparam logic [2:0] OP_SHR = 3'd4;
  localparam logic [2:0] OP_SHL = 3'd5;

  localparam int F_GRP     = 19;
  localparam int F_OP_LO   = 16;
  localparam int F_RD_LO   = 14;
  localparam int F_RS_LO   = 12;
  localparam int F_RT_LO   = 10;
  localparam int F_IMM_SEL = 9;
  localparam int F_RSVD    = 8;
  localparam int F_IMM_LO  = 0;

  localparam int FLAG_C = 0;
  localparam int FLAG_B = 1;
  localparam int FLAG_Z = 2;
  localparam int FLAG_P = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WB    = 2'd2
  } state_t;

  typedef struct packed {
    logic       grp;
    logic [2:0] opcode;
    logic [1:0] rd;
    logic [1:0] rs;
    logic [1:0] rt;
    logic       imm_sel;
    logic       rsvd;
    logic [7:0] imm8;
  } instr_t;

  function automatic instr_t decode(input logic [19:0] w);
    instr_t d;
    d.grp     = w[F_GRP];
    d.opcode  = w[F_OP_LO+:3];
    d.rd      = w[F_RD_LO+:2];
    d.rs      = w[F_RS_LO+:2];
    d.rt      = w[F_RT_LO+:2];
    d.imm_sel = w[F_IMM_SEL];
    d.rsvd    = w[F_RSVD];
    d.imm8    = w[F_IMM_LO+:8];
    return d;
  endfunction

  function automatic logic is_legal(input logic grp, input logic [2:0] op);
    return (grp == GRP_ARITH) ? (op <= OP_SBB) : (op <= OP_SHL);
  endfunction

endpackage

// File: rtl/alu_ctrl_regfile.sv
// Register file for alu_ctrl: two operand read ports, one debug read port and a
// single write port; async active-low reset clears every entry.
module alu_ctrl_regfile
  import alu_pkg::*;
#(
  parameter int NREGS = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       we,
  input  logic [1:0] waddr,
  input  logic [7:0] wdata,
  input  logic [1:0] rs_addr,
  input  logic [1:0] rt_addr,
  input  logic [1:0] dbg_addr,
  output logic [7:0] rs_data,
  output logic [7:0] rt_data,
  output logic [7:0] dbg_data
);

  logic [NREGS-1:0][7:0] mem_q, mem_d;

  always_comb begin
    mem_d = mem_q;
    if (we) mem_d[waddr] = wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) mem_q <= '0;
    else        mem_q <= mem_d;
  end

  assign rs_data  = mem_q[rs_addr];
  assign rt_data  = mem_q[rt_addr];
  assign dbg_data = mem_q[dbg_addr];

endmodule

// File: rtl/alu_ctrl.sv
// Serial issue/writeback controller for the 8-bit ALU (IDLE -> ISSUE -> WB).
// Optional build macro ALU_CTRL_IMM_EN lets imm_sel route imm8 onto alu_op3.
module alu_ctrl
  import alu_pkg::*;
#(
  parameter int NREGS = 4,
  parameter int IW    = 20
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  input  logic [IW-1:0] in_instr,
  output logic          in_ready,
  output logic          alu_grp,
  output logic [2:0]    alu_opcode,
  output logic [7:0]    alu_op1,
  output logic [7:0]    alu_op2,
  output logic [7:0]    alu_op3,
  output logic [3:0]    alu_flags,
  input  logic [7:0]    alu_result,
  input  logic [3:0]    alu_flags_in,
  output logic          done,
  output logic          err,
  input  logic [1:0]    dbg_addr,
  output logic [7:0]    dbg_data,
  output logic [3:0]    flags
);

  state_t     state_q, state_d;
  logic [1:0] rd_q, rd_d;
  logic       grp_q, grp_d;
  logic       alu_grp_q, alu_grp_d;
  logic [2:0] alu_opcode_q, alu_opcode_d;
  logic [7:0] alu_op1_q, alu_op1_d;
  logic [7:0] alu_op3_q, alu_op3_d;
  logic [3:0] alu_flags_q, alu_flags_d;
  logic [3:0] flags_q, flags_d;
  logic       done_q, done_d;
  logic       err_q, err_d;
  logic       we;
  logic [7:0] rs_data, rt_data, op3_sel;
  instr_t     dec;

  assign dec = decode(in_instr[19:0]);

  alu_ctrl_regfile #(.NREGS(NREGS)) u_rf (
    .clk      (clk),
    .rst_n    (rst_n),
    .we       (we),
    .waddr    (rd_q),
    .wdata    (alu_result),
    .rs_addr  (dec.rs),
    .rt_addr  (dec.rt),
    .dbg_addr (dbg_addr),
    .rs_data  (rs_data),
    .rt_data  (rt_data),
    .dbg_data (dbg_data)
  );

`ifdef ALU_CTRL_IMM_EN
  assign op3_sel = dec.imm_sel ? dec.imm8 : rt_data;
`else
  assign op3_sel = rt_data;
`endif

  logic unused_bits;
  assign unused_bits = ^{dec.rsvd, dec.imm_sel, dec.imm8};

  // Operands are captured on the accept edge; nothing writes the register file
  // between accept and ISSUE, so this equals an ISSUE-cycle read and keeps the
  // ALU inputs glitch-free and held afterwards.
  always_comb begin
    state_d      = state_q;
    rd_d         = rd_q;
    grp_d        = grp_q;
    alu_grp_d    = alu_grp_q;
    alu_opcode_d = alu_opcode_q;
    alu_op1_d    = alu_op1_q;
    alu_op3_d    = alu_op3_q;
    alu_flags_d  = alu_flags_q;
    flags_d      = flags_q;
    done_d       = 1'b0;
    err_d        = 1'b0;
    we           = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          if (is_legal(dec.grp, dec.opcode)) begin
            state_d      = ST_ISSUE;
            rd_d         = dec.rd;
            grp_d        = dec.grp;
            alu_grp_d    = dec.grp;
            alu_opcode_d = dec.opcode;
            alu_op1_d    = rs_data;
            alu_op3_d    = op3_sel;
            alu_flags_d  = flags_q;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_ISSUE: state_d = ST_WB;
      ST_WB: begin
        we      = 1'b1;
        done_d  = 1'b1;
        state_d = ST_IDLE;
        if (grp_q == GRP_ARITH) flags_d = alu_flags_in;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      rd_q         <= '0;
      grp_q        <= 1'b0;
      alu_grp_q    <= 1'b0;
      alu_opcode_q <= '0;
      alu_op1_q    <= '0;
      alu_op3_q    <= '0;
      alu_flags_q  <= '0;
      flags_q      <= '0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      rd_q         <= rd_d;
      grp_q        <= grp_d;
      alu_grp_q    <= alu_grp_d;
      alu_opcode_q <= alu_opcode_d;
      alu_op1_q    <= alu_op1_d;
      alu_op3_q    <= alu_op3_d;
      alu_flags_q  <= alu_flags_d;
      flags_q      <= flags_d;
      done_q       <= done_d;
      err_q        <= err_d;
    end
  end

  assign in_ready   = (state_q == ST_IDLE);
  assign alu_grp    = alu_grp_q;
  assign alu_opcode = alu_opcode_q;
  assign alu_op1    = alu_op1_q;
  assign alu_op2    = alu_op1_q;
  assign alu_op3    = alu_op3_q;
  assign alu_flags  = alu_flags_q;
  assign flags      = flags_q;
  assign done       = done_q;
  assign err        = err_q;

endmodule

// File: tb/tb_alu_ctrl.sv
// Bench for alu_ctrl: behavioural ALU stand-in plus an array-based model of the
// register file and flags; directed tests followed by random instructions.
module tb_alu_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [19:0] in_instr;
  logic        in_ready;
  logic        alu_grp;
  logic [2:0]  alu_opcode;
  logic [7:0]  alu_op1, alu_op2, alu_op3;
  logic [3:0]  alu_flags;
  logic [7:0]  alu_result;
  logic [3:0]  alu_flags_in;
  logic        done, err;
  logic [1:0]  dbg_addr;
  logic [7:0]  dbg_data;
  logic [3:0]  flags;

  int nchk = 0;
  int nfail = 0;

  logic [7:0] mr [4];
  logic [3:0] mf;
  bit         ovr_en;
  logic [7:0] ovr_val;

  always #5 clk = ~clk;

  alu_ctrl dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_instr(in_instr),
    .in_ready(in_ready), .alu_grp(alu_grp), .alu_opcode(alu_opcode),
    .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_op3(alu_op3),
    .alu_flags(alu_flags), .alu_result(alu_result), .alu_flags_in(alu_flags_in),
    .done(done), .err(err), .dbg_addr(dbg_addr), .dbg_data(dbg_data),
    .flags(flags)
  );

  // Reference ALU: returns {flags[3:0], result[7:0]}; flags are {P,Z,B,C}.
  function automatic logic [11:0] alu_fn(input logic g, input logic [2:0] op,
                                         input logic [7:0] a, input logic [7:0] b,
                                         input logic [3:0] fin);
    int r;
    logic c, bo;
    logic [7:0] y;
    c = 1'b0; bo = 1'b0; y = 8'h00;
    if (!g) begin
      case (op)
        3'd0: r = int'(a) + int'(b);
        3'd1: r = int'(a) + int'(b) + int'(fin[0]);
        3'd2: r = int'(a) - int'(b);
        default: r = int'(a) - int'(b) - int'(fin[1]);
      endcase
      y = r[7:0];
      if (op <= 3'd1) c = (r > 255);
      else            bo = (r < 0);
    end else begin
      case (op)
        3'd0: y = a & b;
        3'd1: y = a | b;
        3'd2: y = {a[0], a[7:1]};
        3'd3: y = {a[6:0], a[7]};
        3'd4: y = a >> 1;
        default: y = a << 1;
      endcase
    end
    return {^y, (y == 8'h00), bo, c, y};
  endfunction

  // External ALU stand-in: registers its result one cycle after sampling.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_result   <= 8'h00;
      alu_flags_in <= 4'h0;
    end else if (ovr_en) begin
      alu_result   <= ovr_val;
      alu_flags_in <= 4'hF;
    end else begin
      {alu_flags_in, alu_result} <= alu_fn(alu_grp, alu_opcode, alu_op1, alu_op3, alu_flags);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_regs(input string tag);
    for (int i = 0; i < 4; i++) begin
      dbg_addr = 2'(i);
      #1;
      chk($sformatf("%s_R%0d", tag, i), {24'h0, dbg_data}, {24'h0, mr[i]});
    end
    chk({tag, "_flags"}, {28'h0, flags}, {28'h0, mf});
  endtask

  function automatic logic [19:0] mk(input logic g, input logic [2:0] op,
                                     input logic [1:0] rd, input logic [1:0] rs,
                                     input logic [1:0] rt, input logic isel,
                                     input logic [7:0] imm);
    return {g, op, rd, rs, rt, isel, 1'b0, imm};
  endfunction

  // Starts in a cycle with in_ready expected high; ends in the done (or err+1) cycle.
  task automatic do_instr(input string tag, input logic [19:0] ins,
                          input bit use_ovr, input logic [7:0] ov);
    logic g, isel, legal;
    logic [2:0] op;
    logic [1:0] rd, rs, rt;
    logic [7:0] imm, b;
    logic [11:0] res;
    int n;
    g = ins[19]; op = ins[18:16]; rd = ins[15:14]; rs = ins[13:12];
    rt = ins[11:10]; isel = ins[9]; imm = ins[7:0];
    legal = g ? (op <= 3'd5) : (op <= 3'd3);
    b = mr[rt];
`ifdef ALU_CTRL_IMM_EN
    if (isel) b = imm;
`endif
    n = 0;
    while (!in_ready && n < 10) begin step(); n++; end
    chk({tag, "_ready_pre"}, {31'h0, in_ready}, 32'h1);
    ovr_en = use_ovr; ovr_val = ov;
    in_valid = 1'b1; in_instr = ins;
    step();
    in_valid = 1'b0; in_instr = 20'($urandom);
    if (!legal) begin
      chk({tag, "_err"}, {31'h0, err}, 32'h1);
      chk({tag, "_err_ready"}, {31'h0, in_ready}, 32'h1);
      chk({tag, "_err_nodone"}, {31'h0, done}, 32'h0);
      step();
      chk({tag, "_err_clr"}, {31'h0, err}, 32'h0);
      chk({tag, "_err_nodone2"}, {31'h0, done}, 32'h0);
      check_regs({tag, "_err"});
      ovr_en = 1'b0;
      return;
    end
    chk({tag, "_iss_ready"}, {31'h0, in_ready}, 32'h0);
    chk({tag, "_iss_done"}, {31'h0, done}, 32'h0);
    chk({tag, "_iss_grp"}, {31'h0, alu_grp}, {31'h0, g});
    chk({tag, "_iss_op"}, {29'h0, alu_opcode}, {29'h0, op});
    chk({tag, "_iss_op1"}, {24'h0, alu_op1}, {24'h0, mr[rs]});
    chk({tag, "_iss_op2"}, {24'h0, alu_op2}, {24'h0, mr[rs]});
    chk({tag, "_iss_op3"}, {24'h0, alu_op3}, {24'h0, b});
    chk({tag, "_iss_flags"}, {28'h0, alu_flags}, {28'h0, mf});
    res = use_ovr ? {4'hF, ov} : alu_fn(g, op, mr[rs], b, mf);
    step();
    chk({tag, "_wb_ready"}, {31'h0, in_ready}, 32'h0);
    chk({tag, "_wb_done"}, {31'h0, done}, 32'h0);
    step();
    mr[rd] = res[7:0];
    if (!g) mf = res[11:8];
    chk({tag, "_done"}, {31'h0, done}, 32'h1);
    chk({tag, "_done_ready"}, {31'h0, in_ready}, 32'h1);
    dbg_addr = rd;
    #1;
    chk({tag, "_rd"}, {24'h0, dbg_data}, {24'h0, mr[rd]});
    chk({tag, "_flags"}, {28'h0, flags}, {28'h0, mf});
    ovr_en = 1'b0;
  endtask

  task automatic load(input logic [1:0] r, input logic [7:0] v);
    do_instr("load", mk(1'b1, 3'd0, r, 2'd0, 2'd0, 1'b0, 8'h00), 1'b1, v);
  endtask

  initial begin
    logic [7:0] exp_or;
    bit seen_done;
    rst_n = 1'b0; in_valid = 1'b0; in_instr = '0; dbg_addr = '0;
    ovr_en = 1'b0; ovr_val = '0;
    for (int i = 0; i < 4; i++) mr[i] = 8'h00;
    mf = 4'h0;
    repeat (3) step();
    rst_n = 1'b1;
    step();

    chk("rst_ready", {31'h0, in_ready}, 32'h1);
    chk("rst_done", {31'h0, done}, 32'h0);
    chk("rst_err", {31'h0, err}, 32'h0);
    chk("rst_alu", {alu_grp, alu_opcode, alu_op1, alu_op2, alu_op3, alu_flags}, 32'h0);
    check_regs("rst");

    load(2'd1, 8'hF0);
    load(2'd2, 8'h20);
    do_instr("add", mk(1'b0, 3'd0, 2'd3, 2'd1, 2'd2, 1'b0, 8'h00), 1'b0, 8'h00);
    chk("add_R3_const", {24'h0, dbg_data}, 32'h10);
    chk("add_flags_const", {28'h0, flags}, 32'h9);

    load(2'd1, 8'h05);
    load(2'd2, 8'h05);
    do_instr("sub", mk(1'b0, 3'd2, 2'd0, 2'd1, 2'd2, 1'b0, 8'h00), 1'b0, 8'h00);
    chk("sub_R0_const", {24'h0, dbg_data}, 32'h0);
    chk("sub_flags_const", {28'h0, flags}, 32'h4);
    do_instr("and_keep", mk(1'b1, 3'd0, 2'd3, 2'd1, 2'd2, 1'b0, 8'h00), 1'b0, 8'h00);
    chk("and_flags_const", {28'h0, flags}, 32'h4);

    load(2'd1, 8'h0F);
    do_instr("or_imm", mk(1'b1, 3'd1, 2'd3, 2'd1, 2'd2, 1'b1, 8'hA0), 1'b0, 8'h00);
`ifdef ALU_CTRL_IMM_EN
    exp_or = 8'hAF;
`else
    exp_or = 8'h0F;
`endif
    chk("or_imm_const", {24'h0, dbg_data}, {24'h0, exp_or});

    do_instr("illegal", mk(1'b1, 3'd6, 2'd1, 2'd2, 2'd3, 1'b0, 8'h00), 1'b0, 8'h00);
    do_instr("illegal0", mk(1'b0, 3'd5, 2'd0, 2'd2, 2'd3, 1'b0, 8'h00), 1'b0, 8'h00);

    for (int i = 0; i < 4; i++) load(2'(i), 8'($urandom));
    for (int k = 0; k < 40; k++) begin
      do_instr($sformatf("rnd%0d", k), 20'($urandom), 1'b0, 8'h00);
    end
    check_regs("rnd_end");

    load(2'd2, 8'h81);
    in_valid = 1'b1;
    in_instr = mk(1'b1, 3'd3, 2'd2, 2'd2, 2'd2, 1'b0, 8'h00);
    step();
    in_valid = 1'b0;
    step();
    rst_n = 1'b0;
    #1;
    chk("rstwb_done", {31'h0, done}, 32'h0);
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) mr[i] = 8'h00;
    mf = 4'h0;
    seen_done = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (done) seen_done = 1'b1;
    end
    chk("rstwb_nodone", {31'h0, seen_done}, 32'h0);
    chk("rstwb_ready", {31'h0, in_ready}, 32'h1);
    chk("rstwb_alu", {alu_grp, alu_opcode, alu_op1, alu_op2, alu_op3, alu_flags}, 32'h0);
    check_regs("rstwb");

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule

// File: doc/alu_ctrl.md
# alu_ctrl

Issue/writeback controller sitting directly upstream and downstream of the 8-bit ALU. It accepts 20-bit instruction words over a valid/ready handshake and reads source operands from a 4×8 register file. It drives the ALU's group, opcode, operand and flag inputs, captures the ALU's registered result one cycle later, and writes the result and flags back. Instructions execute strictly serially, with no overlap.

## Interface
- NREGS, 4, register-file depth; fixed at 4, with 2-bit register addresses.
- IW, 20, instruction word width.
- clk  in  1  rising-edge clock. One clock domain.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  instruction word present.
- in_instr  in  20  instruction. Fields:
  - [19] grp, [18:16] opcode
  - [15:14] rd, [13:12] rs, [11:10] rt
  - [9] imm_sel, [8] reserved, [7:0] imm8
- in_ready  out  1  controller can accept.
- alu_grp  out  1  to ALU grp.
- alu_opcode  out  3  to ALU opcode.
- alu_op1  out  8  to ALU operand1; always R[rs].
- alu_op2  out  8  to ALU operand2; always R[rs].
- alu_op3  out  8  to ALU operand3; R[rt], or imm8 when immediate is enabled and selected.
- alu_flags  out  4  to ALU flags; always the flag register.
- alu_result  in  8  from ALU finaloperand.
- alu_flags_in  in  4  from ALU outflags1. Bit 0 = carry, 1 = borrow, 2 = zero, 3 = parity.
- done  out  1  one-cycle pulse on writeback.
- err  out  1  one-cycle pulse on an illegal opcode.
- dbg_addr  in  2  register-file debug read address.
- dbg_data  out  8  combinational R[dbg_addr].
- flags  out  4  flag register.

## Operation
- States are IDLE, ISSUE and WB, encoded 2 bits. Reset state is IDLE.
- IDLE
  - in_ready=1.
  - On in_valid at a rising edge, the instruction is latched.
  - Legal opcode: go to ISSUE.
  - Illegal opcode: err pulses in the next cycle, no state change occurs, and the FSM stays in IDLE.
- Legal opcodes:
  - grp=0: 000–011 (ADD/ADC/SUB/SBB).
  - grp=1: 000–101 (AND/OR/ROR/ROL/SHR/SHL).
  - Everything else is illegal.
- ISSUE
  - in_ready=0.
  - ALU outputs are driven from the latched instruction and the current register file and flags.
  - Next state is WB.
- WB
  - in_ready=0.
  - At the closing edge, R[rd] ← alu_result.
  - If grp=0, flags ← alu_flags_in. If grp=1, flags are unchanged.
  - done pulses during the cycle after WB.
  - Next state is IDLE.
- ALU outputs hold their last-driven values outside ISSUE. They are all zero after reset.
- rd may equal rs or rt. Sources are read in ISSUE, before the write.
- Reset values:
  - All registers = 0, flags = 0.
  - in_ready = 1 once out of reset; done = 0, err = 0.
  - Every ALU output = 0.
- Reset asserted mid-instruction: the instruction is abandoned with no writeback, no done and no flag update.

## Timing
- Accept at edge E0. ISSUE occupies the cycle after E0; the ALU samples at edge E1.
- The WB cycle sees the ALU result. Writeback happens at E2. done is high and the result is visible on dbg_data in the cycle after E2.
- Throughput is one instruction per 3 cycles. in_ready returns high in the cycle after E2, together with done.
- A dependent back-to-back instruction reads the updated value with no bypass.
- in_valid while in_ready=0 is ignored. The producer must hold the instruction until accepted.
- dbg_data is combinational. A read of rd in the done cycle returns the new value.

## Configuration
- ALU_CTRL_IMM_EN
  - Defined: when imm_sel=1, alu_op3 = imm8.
  - Undefined: imm_sel and imm8 are ignored, and alu_op3 is always R[rt].
- Both builds decode legality identically.

## Structure
- Shared package alu_pkg holds:
  - group and opcode localparams (OP_ADD…OP_SHL);
  - instruction field bit positions;
  - the FSM state encoding;
  - flag bit indices (FLAG_C, FLAG_B, FLAG_Z, FLAG_P).
- Sub-module alu_ctrl_regfile:
  - 4×8 storage with two combinational read ports (rs, rt) plus the debug read port;
  - one write port;
  - asynchronous active-low reset to zero.

## Test plan
- Reset, then dbg reads of R0–R3 → all 0x00; flags = 0; in_ready = 1.
- R1=0xF0, R2=0x20, ADD rd=3 (grp0/000) → done 3 cycles after accept; R3 = 0x10; flags carry = 1, zero = 0, parity = 1.
- R1=0x05, R2=0x05, SUB rd=0 → R0 = 0x00; flags borrow = 0, zero = 1. A following grp1 AND leaves flags unchanged.
- With ALU_CTRL_IMM_EN, OR rs=1 (R1=0x0F), imm_sel=1, imm8=0xA0 → R[rd] = 0xAF. Without the macro, the same instruction uses R[rt].
- grp1 opcode 110 → err pulse one cycle after accept; no done; register file and flags unchanged; in_ready stays 1.
- Accept ROL with R2=0x81, then drop rst_n during WB → no writeback; R2 reads 0x00 after reset; done never pulses.
